// File: rtl/controller_pkg.sv
// Shared types and constants for the hash-cracker controller.
package controller_pkg;

    localparam int          NUM_POS   = 8;
    localparam int          MAX_CHARS = 16;
    localparam logic [31:0] HASH_MUL  = 32'd33;
    localparam logic [7:0]  NL        = 8'h0A;
    localparam logic [7:0]  FAIL_CHAR = 8'h2D;

    typedef enum logic [2:0] {
        ST_LOAD_CS   = 3'd0,
        ST_LOAD_SEED = 3'd1,
        ST_LOAD_GOAL = 3'd2,
        ST_SEARCH    = 3'd3,
        ST_REPORT    = 3'd4
    } state_e;

    function automatic logic [31:0] hash_step(input logic [31:0] h, input logic [7:0] c);
        return (h * HASH_MUL) ^ {24'd0, c};
    endfunction

endpackage

// File: rtl/controller_uart.sv
// 8N1 UART: synchronised rx deserialiser and tx serialiser with valid/ready byte ports.
module controller_uart #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_busy_o
);
    localparam int             CW      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  CPB_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e     rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_valid_q;

    logic [9:0]    tx_shift_q;
    logic [3:0]    tx_bit_q;
    logic [CW-1:0] tx_cnt_q;
    logic          tx_busy_q, tx_q;
    logic          tx_last_s;

    // Synchronise rx; the third flop gives the falling-edge reference for start detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receive FSM: sample each bit at its middle, drop frames whose stop bit is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_M1) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == CPB_M1) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == CPB_M1) begin
                        rx_cnt_q   <= '0;
                        rx_valid_q <= rx_sync_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_data_o  = rx_shift_q;
    assign rx_valid_o = rx_valid_q;

    // Accepting during the final stop-bit cycle lets frames run back to back.
    assign tx_last_s  = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == CPB_M1);
    assign tx_ready_o = !tx_busy_q || tx_last_s;
    assign tx_busy_o  = tx_busy_q;
    assign tx_o       = tx_q;

    // Transmit shifter: frame is {stop, data[7:0], start}, shifted out LSB first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_shift_q <= 10'h3FF;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else if (tx_valid_i && tx_ready_o) begin
            tx_shift_q <= {1'b1, tx_data_i, 1'b0};
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b1;
            tx_q       <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == CPB_M1) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    tx_bit_q   <= tx_bit_q + 4'd1;
                    tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                    tx_q       <= tx_shift_q[1];
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end else begin
            tx_q <= 1'b1;
        end
    end

endmodule

// File: rtl/controller.sv
// Hash-cracker top: loads a job over UART, tests one 8-char candidate per clock,
// and reports the first match (or "-") back over UART.
module controller
    import controller_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic fpgaclk,
    input  logic reset,
    input  logic rx,
    output logic tx
);
    state_e      state_q;
    logic [7:0]  cs_q    [NUM_POS][MAX_CHARS];
    logic [4:0]  cnt_q   [NUM_POS];
    logic [3:0]  idx_q   [NUM_POS];
    logic [7:0]  match_q [NUM_POS];
    logic [2:0]  pos_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] seed_q, goal_q;
    logic        found_q, rep_sent_q;
    logic [3:0]  rep_idx_q;

    logic [7:0]  rx_data_s, tx_data_s;
    logic        rx_valid_s, tx_valid_s, tx_ready_s, tx_busy_s, tx_last_s;
    logic [7:0]  cand_s     [NUM_POS];
    logic [31:0] hash_s     [NUM_POS+1];
    logic [3:0]  idx_next_s [NUM_POS];
    logic        carry_s, any_empty_s;

    controller_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk_i      (fpgaclk),
        .rst_ni     (reset),
        .rx_i       (rx),
        .tx_o       (tx),
        .rx_data_o  (rx_data_s),
        .rx_valid_o (rx_valid_s),
        .tx_data_i  (tx_data_s),
        .tx_valid_i (tx_valid_s),
        .tx_ready_o (tx_ready_s),
        .tx_busy_o  (tx_busy_s)
    );

    // Current candidate and its hash through eight chained stages.
    always_comb begin
        hash_s[0] = seed_q;
        for (int p = 0; p < NUM_POS; p++) begin
            cand_s[p]   = cs_q[p][idx_q[p]];
            hash_s[p+1] = hash_step(hash_s[p], cand_s[p]);
        end
    end

    // Odometer increment, last position fastest; carry out of position 0 means exhausted.
    always_comb begin
        carry_s     = 1'b1;
        any_empty_s = 1'b0;
        for (int p = NUM_POS - 1; p >= 0; p--) begin
            idx_next_s[p] = idx_q[p];
            if (cnt_q[p] == 5'd0) begin
                any_empty_s = 1'b1;
            end else begin
                any_empty_s = any_empty_s;
            end
            if (carry_s) begin
                if (({1'b0, idx_q[p]} + 5'd1) == cnt_q[p]) begin
                    idx_next_s[p] = 4'd0;
                end else begin
                    idx_next_s[p] = idx_q[p] + 4'd1;
                    carry_s       = 1'b0;
                end
            end else begin
                idx_next_s[p] = idx_q[p];
            end
        end
    end

    // Report byte sequence: eight matched chars then NL, or FAIL_CHAR then NL.
    always_comb begin
        tx_data_s = NL;
        tx_last_s = 1'b0;
        if (found_q) begin
            if (rep_idx_q < 4'd8) begin
                tx_data_s = match_q[rep_idx_q[2:0]];
            end else begin
                tx_last_s = 1'b1;
            end
        end else begin
            if (rep_idx_q == 4'd0) begin
                tx_data_s = FAIL_CHAR;
            end else begin
                tx_last_s = 1'b1;
            end
        end
    end

    assign tx_valid_s = (state_q == ST_REPORT) && !rep_sent_q;

    // Job controller FSM.
    always_ff @(posedge fpgaclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOAD_CS;
            pos_q      <= 3'd0;
            byte_cnt_q <= 2'd0;
            seed_q     <= 32'd0;
            goal_q     <= 32'd0;
            found_q    <= 1'b0;
            rep_sent_q <= 1'b0;
            rep_idx_q  <= 4'd0;
            for (int p = 0; p < NUM_POS; p++) begin
                cnt_q[p]   <= 5'd0;
                idx_q[p]   <= 4'd0;
                match_q[p] <= 8'd0;
                for (int i = 0; i < MAX_CHARS; i++) begin
                    cs_q[p][i] <= 8'd0;
                end
            end
        end else begin
            case (state_q)
                ST_LOAD_CS: begin
                    if (rx_valid_s) begin
                        if (rx_data_s == NL) begin
                            pos_q <= pos_q + 3'd1;
                            if (pos_q == 3'(NUM_POS - 1)) begin
                                byte_cnt_q <= 2'd0;
                                state_q    <= ST_LOAD_SEED;
                            end
                        end else if (cnt_q[pos_q] < 5'(MAX_CHARS)) begin
                            cs_q[pos_q][cnt_q[pos_q][3:0]] <= rx_data_s;
                            cnt_q[pos_q] <= cnt_q[pos_q] + 5'd1;
                        end
                    end
                end
                ST_LOAD_SEED: begin
                    if (rx_valid_s) begin
                        seed_q     <= {seed_q[23:0], rx_data_s};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= ST_LOAD_GOAL;
                        end
                    end
                end
                ST_LOAD_GOAL: begin
                    if (rx_valid_s) begin
                        goal_q     <= {goal_q[23:0], rx_data_s};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            for (int p = 0; p < NUM_POS; p++) begin
                                idx_q[p] <= 4'd0;
                            end
                            state_q <= ST_SEARCH;
                        end
                    end
                end
                ST_SEARCH: begin
                    rep_idx_q  <= 4'd0;
                    rep_sent_q <= 1'b0;
                    if (any_empty_s) begin
                        found_q <= 1'b0;
                        state_q <= ST_REPORT;
                    end else if (hash_s[NUM_POS] == goal_q) begin
                        found_q <= 1'b1;
                        for (int p = 0; p < NUM_POS; p++) begin
                            match_q[p] <= cand_s[p];
                        end
                        state_q <= ST_REPORT;
                    end else if (carry_s) begin
                        found_q <= 1'b0;
                        state_q <= ST_REPORT;
                    end else begin
                        for (int p = 0; p < NUM_POS; p++) begin
                            idx_q[p] <= idx_next_s[p];
                        end
                    end
                end
                ST_REPORT: begin
                    if (!rep_sent_q) begin
                        if (tx_ready_s) begin
                            rep_idx_q <= rep_idx_q + 4'd1;
                            if (tx_last_s) begin
                                rep_sent_q <= 1'b1;
                            end
                        end
                    end else if (!tx_busy_s) begin
                        // Last byte has fully left the line: wipe the job and start over.
                        pos_q      <= 3'd0;
                        byte_cnt_q <= 2'd0;
                        for (int p = 0; p < NUM_POS; p++) begin
                            cnt_q[p] <= 5'd0;
                            idx_q[p] <= 4'd0;
                        end
                        state_q <= ST_LOAD_CS;
                    end
                end
                default: state_q <= ST_LOAD_CS;
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: drives jobs over rx, decodes tx, compares against a reference model.
module tb_controller;
    localparam int CPB        = 8;
    localparam int WAIT_LIMIT = 20000;

    logic fpgaclk = 1'b0;
    logic reset   = 1'b0;
    logic rx      = 1'b1;
    logic tx;

    int unsigned  cyc = 0;
    int           checks = 0;
    int           failures = 0;
    byte unsigned exp_q[$];
    byte unsigned job_cs [8][24];
    int           job_len [8];
    int unsigned  last_stop_cyc = 0;
    int unsigned  start_cyc = 0;
    bit           want_start = 1'b0;
    int           base_lat = -1;
    bit           mdl_found;
    byte unsigned mdl_chars [8];
    int           mdl_sc;

    controller #(.CLKS_PER_BIT(CPB)) dut (
        .fpgaclk (fpgaclk),
        .reset   (reset),
        .rx      (rx),
        .tx      (tx)
    );

    always #5 fpgaclk = ~fpgaclk;
    always @(posedge fpgaclk) cyc <= cyc + 1;

    // Monitor: decode tx frames and compare each byte with the scoreboard head.
    initial begin : monitor
        byte unsigned d;
        byte unsigned e;
        logic         stopb;
        forever begin
            @(negedge fpgaclk);
            if (reset === 1'b1 && tx === 1'b0) begin
                if (want_start) begin
                    start_cyc  = cyc;
                    want_start = 1'b0;
                end
                repeat (CPB / 2) @(negedge fpgaclk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge fpgaclk);
                    d[i] = tx;
                end
                repeat (CPB) @(negedge fpgaclk);
                stopb = tx;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected got=%02h stop=%0b required=no byte", d, stopb);
                end else begin
                    e = exp_q.pop_front();
                    if (d !== e || stopb !== 1'b1) begin
                        failures++;
                        $display("FAIL tx_byte got=%02h stop=%0b required=%02h stop=1", d, stopb, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3ms;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] hash8(input logic [31:0] seed, input byte unsigned c [8]);
        logic [31:0] h;
        h = seed;
        for (int p = 0; p < 8; p++) h = (h * 32'd33) ^ {24'd0, c[p]};
        return h;
    endfunction

    // Reference: walk candidates in mixed-radix order (last position fastest), first match wins.
    task automatic model(input logic [31:0] seed, input logic [31:0] goal);
        int           len [8];
        longint       total;
        longint       rem;
        byte unsigned c [8];
        total     = 1;
        mdl_found = 1'b0;
        mdl_sc    = 1;
        for (int p = 0; p < 8; p++) begin
            len[p] = (job_len[p] > 16) ? 16 : job_len[p];
            total  = total * len[p];
        end
        if (total == 0) return;
        for (longint k = 0; k < total; k++) begin
            rem = k;
            for (int p = 7; p >= 0; p--) begin
                c[p] = job_cs[p][int'(rem % len[p])];
                rem  = rem / len[p];
            end
            if (hash8(seed, c) == goal) begin
                mdl_found = 1'b1;
                mdl_chars = c;
                mdl_sc    = int'(k) + 1;
                return;
            end
        end
        mdl_sc = int'(total);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge fpgaclk);
    endtask

    task automatic set_cs(input int p, input string s);
        job_len[p] = s.len();
        for (int i = 0; i < s.len(); i++) job_cs[p][i] = s[i];
    endtask

    task automatic send_byte(input byte unsigned b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        last_stop_cyc = cyc;
        tick(CPB);
        rx = 1'b1;
        if (!stop_bit) tick(2 * CPB);
    endtask

    task automatic send_job(input logic [31:0] seed, input logic [31:0] goal, input bit gap, input bit bad);
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < job_len[p]; i++) send_byte(job_cs[p][i], 1'b1);
            if (bad && p == 0) send_byte(8'h0A, 1'b0);
            send_byte(8'h0A, 1'b1);
        end
        for (int i = 3; i >= 0; i--) send_byte(seed[8*i +: 8], 1'b1);
        for (int i = 3; i >= 0; i--) begin
            if (gap && i == 0) tick(1000);
            send_byte(goal[8*i +: 8], 1'b1);
        end
    endtask

    task automatic run_job(input string name, input logic [31:0] seed, input logic [31:0] goal,
                           input bit gap, input bit bad);
        int n;
        int lat;
        model(seed, goal);
        if (mdl_found) begin
            for (int p = 0; p < 8; p++) exp_q.push_back(mdl_chars[p]);
        end else begin
            exp_q.push_back(8'h2D);
        end
        exp_q.push_back(8'h0A);
        want_start = 1'b1;
        send_job(seed, goal, gap, bad);
        n = 0;
        while (want_start && n < WAIT_LIMIT) begin
            tick(1);
            n++;
        end
        checks++;
        if (want_start) begin
            failures++;
            want_start = 1'b0;
            $display("FAIL %s report_timeout waited=%0d cycles required=start bit", name, n);
        end else begin
            lat = int'(start_cyc - last_stop_cyc) - mdl_sc;
            if (base_lat < 0) begin
                if (lat < 1 || lat > 3 * CPB) begin
                    failures++;
                    $display("FAIL %s base_latency got=%0d required=1..%0d", name, lat, 3 * CPB);
                end
                base_lat = lat;
            end else if (lat != base_lat) begin
                failures++;
                $display("FAIL %s search_cycles got=%0d required=%0d", name, lat - base_lat + mdl_sc, mdl_sc);
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < WAIT_LIMIT) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s report_incomplete missing=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        tick(3 * CPB);
    endtask

    initial begin : main
        byte unsigned c [8];
        string        s;
        logic [31:0]  seed;
        logic [31:0]  goal;
        int           bad_cycles;

        repeat (4) @(negedge fpgaclk);
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx got=%0b required=1", tx);
        end
        reset = 1'b1;
        tick(4);
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL idle_tx got=%0b required=1", tx);
        end

        for (int p = 0; p < 8; p++) set_cs(p, "A");
        run_job("all_A_match", 32'h0000_0000, 32'h0D1F_7080, 1'b0, 1'b0);
        run_job("all_A_nomatch", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

        for (int p = 5; p < 8; p++) set_cs(p, "AGILMY");
        s = "AAAAAYMG";
        for (int i = 0; i < 8; i++) c[i] = s[i];
        run_job("agilmy_match_gap", 32'h0482_1427, hash8(32'h0482_1427, c), 1'b1, 1'b0);
        run_job("agilmy_unreachable", 32'h0482_1427, 32'hFFFF_FFFF, 1'b0, 1'b0);

        for (int p = 0; p < 8; p++) set_cs(p, "A");
        set_cs(3, "");
        run_job("empty_pos3", 32'h0000_0000, 32'h0D1F_7080, 1'b0, 1'b0);

        for (int p = 0; p < 8; p++) set_cs(p, "A");
        set_cs(0, "ABCDEFGHIJKLMNOPQRST");
        s = "QAAAAAAA";
        for (int i = 0; i < 8; i++) c[i] = s[i];
        run_job("overflow_17th", 32'h1234_5678, hash8(32'h1234_5678, c), 1'b0, 1'b0);
        s = "PAAAAAAA";
        for (int i = 0; i < 8; i++) c[i] = s[i];
        run_job("overflow_16th", 32'h1234_5678, hash8(32'h1234_5678, c), 1'b0, 1'b0);

        for (int p = 0; p < 8; p++) set_cs(p, "A");
        run_job("bad_stop_frame", 32'h0000_0000, 32'h0D1F_7080, 1'b0, 1'b1);

        for (int j = 0; j < 4; j++) begin
            for (int p = 0; p < 8; p++) begin
                job_len[p] = $urandom_range(1, 2);
                for (int i = 0; i < job_len[p]; i++) job_cs[p][i] = 8'($urandom_range(33, 126));
            end
            seed = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                for (int p = 0; p < 8; p++) c[p] = job_cs[p][$urandom_range(0, job_len[p] - 1)];
                goal = hash8(seed, c);
            end else begin
                goal = $urandom;
            end
            run_job($sformatf("random_%0d", j), seed, goal, 1'b0, 1'b0);
        end

        for (int p = 0; p < 5; p++) set_cs(p, "A");
        for (int p = 5; p < 8; p++) set_cs(p, "abcdefghijklmnop");
        send_job(32'hCAFE_0001, 32'h0000_0001, 1'b0, 1'b0);
        tick(100);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_search_tx got=%0b required=1", tx);
        end
        tick(4);
        reset = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (tx !== 1'b1) bad_cycles++;
        end
        checks++;
        if (bad_cycles != 0) begin
            failures++;
            $display("FAIL post_reset_idle low_cycles=%0d required=0", bad_cycles);
        end

        for (int p = 0; p < 8; p++) set_cs(p, "A");
        run_job("after_reset_job", 32'h0000_0000, 32'h0D1F_7080, 1'b0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
